id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  RV32I decode/operand stage between fetch and execute. Decodes instr, drives register_file read addrs, bypasses
//  same-cycle writeback (reg file array write lands at edge, read is combinational), builds immediate, registers
//  result into ID/EX output slot with valid/ready handshake; inserts load-use bubbles.
// PARAMETERS
//  LOAD_USE_BUBBLES  1  bubbles forced between a load and a dependent instr (1..3; EX forwards ALU results)
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  if_valid      in   1   fetch offers instr
//  if_ready      out  1   stage accepts instr this cycle
//  if_instr      in   32  instruction word
//  if_pc         in   32  instruction PC
//  rf_rs1_addr   out  5   = if_instr[19:15], combinational
//  rf_rs2_addr   out  5   = if_instr[24:20], combinational
//  rf_rs1_data   in   32  register file read data 1
//  rf_rs2_data   in   32  register file read data 2
//  wb_rd_we      in   1   writeback write enable (same signals driving register_file write port)
//  wb_rd_addr    in   5   writeback dest
//  wb_rd_data    in   32  writeback data
//  flush         in   1   branch/jump redirect from EX: kill slot
//  ex_valid      out  1   ID/EX slot holds instr
//  ex_ready      in   1   EX consumes slot
//  ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out 32 each; registered operands/immediate
//  ex_rd_addr    out  5   dest (0 if format has no rd)
//  ex_opcode     out  7;  ex_funct3 out 3;  ex_funct7b5 out 1 (instr[30])
//  ex_illegal    out  1   illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: ex_valid=0, all ex_* data outputs 0, hz_cnt=0, hz_rd=0. if_ready low while rst.
//  - Slot free = !ex_valid || ex_ready. if_ready = slot_free && !hazard && !flush. Accept = if_valid && if_ready.
//  - Accept: capture decode + operands next edge, ex_valid<=1. Slot free, no accept: ex_valid<=0 (bubble).
//    Slot held (ex_valid && !ex_ready): all ex_* stable.
//  - Latency: 1 cycle if_* -> ex_*. Full throughput 1 instr/cycle absent hazards.
//  - Bypass: rsN_val = (wb_rd_we && wb_rd_addr!=0 && wb_rd_addr==rsN) ? wb_rd_data : rf_rsN_data; x0 always 0.
//  - rs usage: rs1 unused by LUI/AUIPC/JAL; rs2 used only by OP, STORE, BRANCH. Unused operand captured as 0.
//  - Immediate: I/S/B/U/J per opcode, sign-extended from instr[31]; B/J bit0=0; R-type imm=0.
//  - Load-use: on accepting LOAD with rd!=0: hz_rd<=rd, hz_cnt<=LOAD_USE_BUBBLES. hz_cnt decrements (sat 0) each
//    cycle slot_free is true and no new load is accepted. hazard = hz_cnt!=0 && used rsN==hz_rd (rsN!=0).
//    Default: load in slot + dependent waiting -> exactly one bubble after load leaves.
//  - Load accepted while hz_cnt!=0: new load overwrites hz_rd/hz_cnt (back-to-back loads).
//  - flush (priority over all): ex_valid<=0, hz_cnt<=0, no accept that cycle regardless of if_valid/ex_ready.
//  - rst asserted mid-operation: immediate return to reset values; in-flight instr discarded.
// CONFIGURATION
//  ID_STAGE_ILLEGAL_EN defined: opcode not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,MISC-MEM,SYSTEM}
//   or instr[1:0]!=2'b11 -> ex_illegal=1, ex_rd_addr=0, no load-use tracking; instr still flows with ex_valid=1.
//  Not defined: ex_illegal tied 0; unknown opcodes decode as R-type with rd passed through.
// STRUCTURE
//  rv32i_pkg: opcode localparams (OPC_LUI..OPC_SYSTEM), imm format enum (IMM_I/S/B/U/J/NONE), XLEN=32.
//  Sub-module imm_gen: combinational instr+format -> 32b immediate. Decode, bypass, hazard, slot in id_stage.
// TESTING
//  1 addi x1,x0,5 (0x00500093) pc=0x100, ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd_addr=1, ex_pc=0x100.
//  2 add x3,x1,x2 with wb_rd_we=1 wb_rd_addr=1 wb_rd_data=0xAA, rf_rs1_data=0x11 -> ex_rs1_val=0xAA; rd=0 write ignored.
//  3 lw x5,0(x1) then add x6,x5,x5 -> add held one cycle, one ex_valid=0 cycle between them; add x6,x4,x4 no bubble.
//  4 ex_ready=0 for 3 cycles with ex_valid=1 -> if_ready=0, ex_* unchanged; release -> next instr 1 cycle later.
//  5 flush with ex_valid=1 and if_valid=1 -> ex_valid=0 next cycle, instr not accepted, pending load hazard cleared.
//  6 beq x1,x2,-8 (0xFE208CE3) -> ex_imm=0xFFFFFFF8, ex_rd_addr=0; opcode 0x7F -> ex_illegal=1 only with ID_STAGE_ILLEGAL_EN.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, immediate formats and decode helpers
package rv32i_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC:                                     return IMM_U;
      OPC_JAL:                                                return IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: return IMM_I;
      OPC_STORE:                                              return IMM_S;
      OPC_BRANCH:                                             return IMM_B;
      default:                                                return IMM_NONE;
    endcase
  endfunction

  function automatic logic opc_known(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate builder, sign-extended from instr[31]
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode/operand stage with WB bypass, load-use bubbles and ID/EX slot
// Optional illegal-opcode flagging is enabled by defining ID_STAGE_ILLEGAL_EN.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_rd_we,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);
  localparam logic [1:0] HZ_INIT = 2'(LOAD_USE_BUBBLES);

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd, rd_eff, hz_rd;
  logic [1:0]      hz_cnt;
  logic            use_rs1, use_rs2, has_rd, illegal, track_load;
  logic            slot_free, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;

  assign opc         = if_instr[6:0];
  assign rd          = if_instr[11:7];
  assign rs1         = if_instr[19:15];
  assign rs2         = if_instr[24:20];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

`ifdef ID_STAGE_ILLEGAL_EN
  assign illegal = !opc_known(opc) || (if_instr[1:0] != 2'b11);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    use_rs1    = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    use_rs2    = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    has_rd     = !(opc == OPC_STORE || opc == OPC_BRANCH);
    rd_eff     = (has_rd && !illegal) ? rd : 5'd0;
    track_load = (opc == OPC_LOAD) && !illegal && (rd != 5'd0);
  end

  // Register-file writes land at the edge, so the same-cycle WB value must be muxed in here.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1 != 5'd0)
      rs1_val = (wb_rd_we && wb_rd_addr == rs1) ? wb_rd_data : rf_rs1_data;
    if (use_rs2 && rs2 != 5'd0)
      rs2_val = (wb_rd_we && wb_rd_addr == rs2) ? wb_rd_data : rf_rs2_data;
  end

  imm_gen u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (imm_fmt_of(opc)),
    .imm   (imm)
  );

  assign slot_free = !ex_valid || ex_ready;
  assign hazard    = (hz_cnt != 2'd0) &&
                     ((use_rs1 && rs1 != 5'd0 && rs1 == hz_rd) ||
                      (use_rs2 && rs2 != 5'd0 && rs2 == hz_rd));
  assign if_ready  = !rst && slot_free && !hazard && !flush;
  assign accept    = if_valid && if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd_addr  <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
      hz_cnt      <= '0;
      hz_rd       <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      hz_cnt   <= '0;
    end else begin
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs1_val  <= rs1_val;
        ex_rs2_val  <= rs2_val;
        ex_imm      <= imm;
        ex_rd_addr  <= rd_eff;
        ex_opcode   <= opc;
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_illegal  <= illegal;
      end else if (slot_free) begin
        ex_valid <= 1'b0;
      end
      // The countdown only advances while the slot drains, so a stalled load keeps its guard.
      if (accept && track_load) begin
        hz_rd  <= rd;
        hz_cnt <= HZ_INIT;
      end else if (slot_free && hz_cnt != 2'd0) begin
        hz_cnt <= hz_cnt - 2'd1;
      end
    end
  end
endmodule
